// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: writeback has priority, long-latency results queue in a FIFO.
// Optional same-cycle bypass of an empty FIFO when RF_ARB_BYPASS_EN is defined.
module rf_wb_arbiter #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_wa,
    input  logic [31:0] wb_wd,
    input  logic        lu_valid,
    input  logic [4:0]  lu_wa,
    input  logic [31:0] lu_wd,
    output logic        lu_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_wa,
    input  logic [4:0]  chk_ra0,
    input  logic [4:0]  chk_ra1,
    input  logic [4:0]  chk_wa,
    output logic        stall,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [31:0] sb_busy
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } lu_entry_t;

    lu_entry_t       mem [DEPTH];
    lu_entry_t       head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [31:0]     busy;
    logic [31:0]     busy_nxt;
    logic            empty;
    logic            full;
    logic            port_free;
    logic            pop;
    logic            push;
    logic            byp;
    logic            clr_en;

    // Pointer MSBs differ with equal index bits only when the FIFO is full.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign port_free = !(wb_we && (wb_wa != 5'd0));
    assign head      = mem[rd_ptr[AW-1:0]];
    assign pop       = !rst && port_free && !empty;
    assign lu_ready  = !full && !rst;

`ifdef RF_ARB_BYPASS_EN
    assign byp = !rst && port_free && empty && lu_valid;
`else
    assign byp = 1'b0;
`endif

    assign push = lu_valid && lu_ready && !byp;

    // Write-port mux: writeback, then FIFO head, then bypassed result.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = 5'd0;
        rf_wd = 32'd0;
        if (rst) begin
            rf_we = 1'b0;
        end else if (!port_free) begin
            rf_we = 1'b1;
            rf_wa = wb_wa;
            rf_wd = wb_wd;
        end else if (pop) begin
            rf_we = (head.wa != 5'd0);
            rf_wa = head.wa;
            rf_wd = head.wd;
        end else if (byp) begin
            rf_we = (lu_wa != 5'd0);
            rf_wa = lu_wa;
            rf_wd = lu_wd;
        end
    end

    // Any port write while the port is free is a long-latency retire.
    assign clr_en = !rst && port_free && rf_we;

    // Clear then set so an issue to the retiring register keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[rf_wa] = 1'b0;
        if (issue_valid && (issue_wa != 5'd0)) busy_nxt[issue_wa] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            busy   <= 32'd0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            busy   <= busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{wa: lu_wa, wd: lu_wd};
    end

    assign sb_busy = rst ? 32'd0 : busy;
    assign stall   = !rst && (busy[chk_ra0] | busy[chk_ra1] | busy[chk_wa]);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: queue/bit-vector reference model checked every cycle plus directed literal checks.
module tb_rf_wb_arbiter;
    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_wa = 5'd0;
    logic [31:0] wb_wd = 32'd0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_wa = 5'd0;
    logic [31:0] lu_wd = 32'd0;
    logic        lu_ready;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_wa = 5'd0;
    logic [4:0]  chk_ra0 = 5'd0;
    logic [4:0]  chk_ra1 = 5'd0;
    logic [4:0]  chk_wa = 5'd0;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] sb_busy;

    int tests = 0;
    int fails = 0;

    rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .lu_valid(lu_valid), .lu_wa(lu_wa), .lu_wd(lu_wd), .lu_ready(lu_ready),
        .issue_valid(issue_valid), .issue_wa(issue_wa),
        .chk_ra0(chk_ra0), .chk_ra1(chk_ra1), .chk_wa(chk_wa),
        .stall(stall), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .sb_busy(sb_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit [4:0]  wa;
        bit [31:0] wd;
    } ent_t;

    ent_t     q[$];
    bit [31:0] m_busy = 32'd0;

    // Reference model: compare outputs mid-cycle, then apply the coming edge.
    always @(negedge clk) begin
        bit        free, byp, e_we, e_rdy, e_stall;
        bit [4:0]  e_wa;
        bit [31:0] e_wd;
        ent_t      h;
        free = !(wb_we && wb_wa != 0);
        byp = 0;
        e_we = 0; e_wa = 0; e_wd = 0;
        if (rst) begin
            chk("m_rf_we", 32'(rf_we), 0);
            chk("m_lu_ready", 32'(lu_ready), 0);
            chk("m_stall", 32'(stall), 0);
            chk("m_sb_busy", sb_busy, 0);
            q.delete();
            m_busy = 0;
        end else begin
            if (!free) begin
                e_we = 1; e_wa = wb_wa; e_wd = wb_wd;
            end else if (q.size() > 0) begin
                h = q[0];
                e_we = (h.wa != 0); e_wa = h.wa; e_wd = h.wd;
            end
`ifdef RF_ARB_BYPASS_EN
            else if (lu_valid) begin
                byp = 1;
                e_we = (lu_wa != 0); e_wa = lu_wa; e_wd = lu_wd;
            end
`endif
            e_rdy = (q.size() < DEPTH);
            e_stall = m_busy[chk_ra0] || m_busy[chk_ra1] || m_busy[chk_wa];
            chk("m_rf_we", 32'(rf_we), 32'(e_we));
            if (e_we) begin
                chk("m_rf_wa", 32'(rf_wa), 32'(e_wa));
                chk("m_rf_wd", rf_wd, e_wd);
            end
            chk("m_lu_ready", 32'(lu_ready), 32'(e_rdy));
            chk("m_stall", 32'(stall), 32'(e_stall));
            chk("m_sb_busy", sb_busy, m_busy);
            if (free && q.size() > 0) void'(q.pop_front());
            if (free && e_we) m_busy[e_wa] = 0;
            if (lu_valid && e_rdy && !byp) q.push_back('{wa: lu_wa, wd: lu_wd});
            if (issue_valid && issue_wa != 0) m_busy[issue_wa] = 1;
            m_busy[0] = 0;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nxt(); nxt();
        rst = 0;
        // Issue to x5 marks it busy and stalls a reader next cycle.
        issue_valid = 1; issue_wa = 5;
        nxt();
        issue_valid = 0; chk_ra0 = 5;
        @(negedge clk);
        chk("stall_after_issue", 32'(stall), 1);
        chk("sb_busy_x5", sb_busy, 32'h20);
        nxt();
        lu_valid = 1; lu_wa = 5; lu_wd = 32'hDEADBEEF;
        @(negedge clk);
`ifdef RF_ARB_BYPASS_EN
        chk("byp_we", 32'(rf_we), 1);
        chk("byp_wd", rf_wd, 32'hDEADBEEF);
        chk("byp_stall_hold", 32'(stall), 1);
        nxt();
        lu_valid = 0;
        @(negedge clk);
        chk("byp_stall_drop", 32'(stall), 0);
`else
        chk("accept_no_write", 32'(rf_we), 0);
        nxt();
        lu_valid = 0;
        @(negedge clk);
        chk("retire_we", 32'(rf_we), 1);
        chk("retire_wa", 32'(rf_wa), 5);
        chk("retire_wd", rf_wd, 32'hDEADBEEF);
        chk("stall_hold", 32'(stall), 1);
        nxt();
        @(negedge clk);
        chk("stall_drop", 32'(stall), 0);
`endif
        chk_ra0 = 0;
        // Writeback hogs the port while three results are offered.
        nxt();
        wb_we = 1; wb_wa = 3; wb_wd = 32'h33;
        lu_valid = 1; lu_wa = 10; lu_wd = 32'hA0;
        @(negedge clk); chk("wb_port_c1", 32'(rf_wa), 3);
        nxt(); lu_wa = 11; lu_wd = 32'hB0;
        @(negedge clk); chk("wb_port_c2", 32'(rf_wa), 3);
        nxt(); lu_wa = 12; lu_wd = 32'hC0;
        @(negedge clk); chk("wb_port_c3", 32'(rf_wa), 3);
        chk("full_not_ready", 32'(lu_ready), 0);
        nxt();
        @(negedge clk); chk("wb_port_c4", 32'(rf_wa), 3);
        nxt(); wb_we = 0;
        @(negedge clk); chk("drain_10", 32'(rf_wa), 10);
        chk("no_passthru_full", 32'(lu_ready), 0);
        nxt();
        @(negedge clk); chk("drain_11", 32'(rf_wa), 11);
        nxt(); lu_valid = 0;
        @(negedge clk); chk("drain_12", 32'(rf_wa), 12);
        chk("drain_12_wd", rf_wd, 32'hC0);
        // x0 writeback leaves the port free for a queued entry.
        nxt();
        wb_we = 1; wb_wa = 4; wb_wd = 32'h44;
        lu_valid = 1; lu_wa = 7; lu_wd = 32'h77;
        @(negedge clk); chk("wb_x4", 32'(rf_wa), 4);
        nxt(); wb_wa = 0; wb_wd = 32'h99; lu_valid = 0;
        @(negedge clk);
        chk("x0_drain_we", 32'(rf_we), 1);
        chk("x0_drain_wa", 32'(rf_wa), 7);
        chk("x0_drain_wd", rf_wd, 32'h77);
        nxt();
        @(negedge clk); chk("x0_wb_no_we", 32'(rf_we), 0);
        // Issue to x0 and a result to x0 have no visible effect.
        nxt(); wb_we = 0; issue_valid = 1; issue_wa = 0;
        nxt(); issue_valid = 0;
        @(negedge clk); chk("issue_x0", sb_busy, 0);
        lu_valid = 1; lu_wa = 0; lu_wd = 32'h55;
        @(negedge clk); chk("lu_x0_c1", 32'(rf_we), 0);
        nxt(); lu_wa = 9; lu_wd = 32'h99;
        @(negedge clk);
`ifdef RF_ARB_BYPASS_EN
        chk("lu9_byp_wa", 32'(rf_wa), 9);
`else
        chk("lu_x0_drop", 32'(rf_we), 0);
        nxt(); lu_valid = 0;
        @(negedge clk); chk("lu9_wa", 32'(rf_wa), 9);
`endif
        chk("lu9_we", 32'(rf_we), 1);
        // Reset with two queued results and x4/x7 busy.
        nxt();
        lu_valid = 1; lu_wa = 4; lu_wd = 32'h1;
        wb_we = 1; wb_wa = 3; issue_valid = 1; issue_wa = 4;
        nxt(); lu_wa = 7; lu_wd = 32'h2; issue_wa = 7;
        nxt(); lu_valid = 0; issue_valid = 0; chk_ra0 = 4;
        @(negedge clk);
        chk("pre_rst_busy", sb_busy, 32'h90);
        chk("pre_rst_full", 32'(lu_ready), 0);
        chk("pre_rst_stall", 32'(stall), 1);
        nxt(); rst = 1;
        @(negedge clk);
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_stall", 32'(stall), 0);
        nxt(); rst = 0; wb_we = 0;
        @(negedge clk);
        chk("post_rst_busy", sb_busy, 0);
        chk("post_rst_ready", 32'(lu_ready), 1);
        chk("post_rst_we", 32'(rf_we), 0);
        chk("post_rst_stall", 32'(stall), 0);
        nxt();
        @(negedge clk); chk("no_stale_1", 32'(rf_we), 0);
        nxt();
        @(negedge clk); chk("no_stale_2", 32'(rf_we), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
